// File: rtl/pc_unit_pkg.sv
// Shared encodings for the program-counter unit: branch condition modes and next-PC sources.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        COND_EQ     = 3'd0,
        COND_NE     = 3'd1,
        COND_GT     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_LE     = 3'd5,
        COND_ALWAYS = 3'd6,
        COND_NEVER  = 3'd7
    } cond_mode_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_EXC    = 2'd3
    } pc_source_e;

endpackage

// File: rtl/pc_unit_branch_cond.sv
// Branch condition evaluator: maps {zf, gf, cond_mode} to cond_true.
// Purely combinational; no backpressure.
module pc_unit_branch_cond
    import pc_unit_pkg::*;
(
    input  logic       zf,
    input  logic       gf,
    input  logic [2:0] cond_mode,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond_mode)
            COND_EQ:     cond_true = zf;
            COND_NE:     cond_true = !zf;
            COND_GT:     cond_true = gf;
            COND_LT:     cond_true = !gf && !zf;
            COND_GE:     cond_true = gf || zf;
            COND_LE:     cond_true = !gf;
            COND_ALWAYS: cond_true = 1'b1;
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter unit: flag register, branch condition, next-PC mux, alignment check, PC/EPC, branch counter.
// Latency 1 cycle for every registered output; no backpressure (loads are accepted or rejected in-cycle).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_BASE     = 'h0000_0080,
    parameter int               CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_zero,
    input  logic                 alu_gt,
    input  logic                 flags_load,
    input  logic                 pc_write,
    input  logic                 pc_write_cond,
    input  logic [2:0]           cond_mode,
    input  logic [1:0]           pc_source,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     aluout,
    input  logic [WIDTH-1:0]     jump_target,
    input  logic [1:0]           exc_code,
    input  logic                 epc_write,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     epc,
    output logic                 pc_taken,
    output logic                 misaligned,
    output logic [CNT_WIDTH-1:0] branch_count
);

    logic             zf_q, gf_q;
    logic             zf, gf;
    logic             cond_true;
    logic             write_en;
    logic             is_exc;
    logic             reject;
    logic             accept;
    logic             cnt_inc;
    logic [WIDTH-1:0] exc_vec;
    logic [WIDTH-1:0] next_pc;

    // Bypass lets a compare and its dependent branch share one cycle.
    assign zf = flags_load ? alu_zero : zf_q;
    assign gf = flags_load ? alu_gt   : gf_q;

    pc_unit_branch_cond u_branch_cond (
        .zf        (zf),
        .gf        (gf),
        .cond_mode (cond_mode),
        .cond_true (cond_true)
    );

    assign write_en = pc_write || (pc_write_cond && cond_true);
    assign exc_vec  = EXC_BASE + {{(WIDTH-4){1'b0}}, exc_code, 2'b00};

    always_comb begin
        next_pc = alu_result;
        case (pc_source)
            PCSRC_ALU:    next_pc = alu_result;
            PCSRC_ALUOUT: next_pc = aluout;
            PCSRC_JUMP:   next_pc = jump_target;
            PCSRC_EXC:    next_pc = exc_vec;
            default:      next_pc = alu_result;
        endcase
    end

    // Exception vectors are trusted; every other target must be word aligned.
    assign is_exc  = (pc_source == PCSRC_EXC);
    assign reject  = write_en && (next_pc[1:0] != 2'b00) && !is_exc;
    assign accept  = write_en && !reject;
    assign cnt_inc = accept && pc_write_cond && !pc_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zf_q         <= 1'b0;
            gf_q         <= 1'b0;
            pc           <= RESET_VECTOR;
            epc          <= '0;
            pc_taken     <= 1'b0;
            misaligned   <= 1'b0;
            branch_count <= '0;
        end else begin
            if (flags_load) begin
                zf_q <= alu_zero;
                gf_q <= alu_gt;
            end
            if (epc_write) begin
                epc <= pc;
            end
            pc_taken <= accept;
            if (accept) begin
                pc <= next_pc;
            end
            if (reject) begin
                misaligned <= 1'b1;
            end else if (accept && is_exc) begin
                misaligned <= 1'b0;
            end
            if (cnt_inc && (branch_count != {CNT_WIDTH{1'b1}})) begin
                branch_count <= branch_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a behavioural model predicts each cycle's outputs, which are compared one edge later.
`timescale 1ns/1ps
module tb_pc_unit;

    localparam int W  = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [W-1:0]  pc;
        logic [W-1:0]  epc;
        logic          taken;
        logic          mis;
        logic [CW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_zero, alu_gt, flags_load, pc_write, pc_write_cond, epc_write;
    logic [2:0]    cond_mode;
    logic [1:0]    pc_source, exc_code;
    logic [W-1:0]  alu_result, aluout, jump_target;
    logic [W-1:0]  pc, epc;
    logic          pc_taken, misaligned;
    logic [CW-1:0] branch_count;

    pc_unit #(.WIDTH(W), .RESET_VECTOR('0), .EXC_BASE('h80), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .alu_zero(alu_zero), .alu_gt(alu_gt),
        .flags_load(flags_load), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .cond_mode(cond_mode), .pc_source(pc_source), .alu_result(alu_result),
        .aluout(aluout), .jump_target(jump_target), .exc_code(exc_code),
        .epc_write(epc_write), .pc(pc), .epc(epc), .pc_taken(pc_taken),
        .misaligned(misaligned), .branch_count(branch_count)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb_q[$];

    // model state
    logic [W-1:0]  m_pc, m_epc;
    logic          m_zf, m_gf, m_taken, m_mis;
    logic [CW-1:0] m_cnt;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    task automatic model_reset();
        m_pc = '0; m_epc = '0; m_zf = 0; m_gf = 0; m_taken = 0; m_mis = 0; m_cnt = '0;
    endtask

    task automatic idle();
        alu_zero = 0; alu_gt = 0; flags_load = 0; pc_write = 0; pc_write_cond = 0;
        epc_write = 0; cond_mode = 3'd7; pc_source = 2'd0; exc_code = 2'd0;
        alu_result = '0; aluout = '0; jump_target = '0;
    endtask

    // Predict the outcome of the currently driven inputs, clock once, then compare.
    task automatic step();
        logic ezf, egf, ct, we;
        logic [W-1:0] tgt;
        exp_t e, got;
        ezf = flags_load ? alu_zero : m_zf;
        egf = flags_load ? alu_gt   : m_gf;
        case (cond_mode)
            3'd0: ct = ezf;
            3'd1: ct = ~ezf;
            3'd2: ct = egf;
            3'd3: ct = ~egf & ~ezf;
            3'd4: ct = egf | ezf;
            3'd5: ct = ~egf;
            3'd6: ct = 1'b1;
            default: ct = 1'b0;
        endcase
        we = pc_write | (pc_write_cond & ct);
        case (pc_source)
            2'd0: tgt = alu_result;
            2'd1: tgt = aluout;
            2'd2: tgt = jump_target;
            default: tgt = 32'h80 + 32'(exc_code) * 4;
        endcase
        if (flags_load) begin m_zf = alu_zero; m_gf = alu_gt; end
        if (epc_write) m_epc = m_pc;
        if (we && tgt[1:0] != 2'b00 && pc_source != 2'd3) begin
            m_mis = 1; m_taken = 0;
        end else if (we) begin
            m_pc = tgt; m_taken = 1;
            if (pc_source == 2'd3) m_mis = 0;
            if (pc_write_cond && !pc_write && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        end else begin
            m_taken = 0;
        end
        sb_q.push_back('{pc: m_pc, epc: m_epc, taken: m_taken, mis: m_mis, cnt: m_cnt});
        @(posedge clk); #1;
        got = '{pc: pc, epc: epc, taken: pc_taken, mis: misaligned, cnt: branch_count};
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check("sb_pc",    got.pc,         e.pc);
            check("sb_epc",   got.epc,        e.epc);
            check("sb_taken", 32'(got.taken), 32'(e.taken));
            check("sb_mis",   32'(got.mis),   32'(e.mis));
            check("sb_cnt",   32'(got.cnt),   32'(e.cnt));
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_taken", 32'(pc_taken), 32'h0);
        check("rst_mis", 32'(misaligned), 32'h0);
        check("rst_cnt", 32'(branch_count), 32'h0);
        reset = 1;
        step();

        // registered flags: zero captured, branch taken next cycle
        flags_load = 1; alu_zero = 1; step();
        pc_write_cond = 1; cond_mode = 3'd0; pc_source = 2'd1; aluout = 32'h40; step();
        check("eq_pc", pc, 32'h40);
        check("eq_taken", 32'(pc_taken), 32'h1);
        check("eq_cnt", 32'(branch_count), 32'h1);
        step();
        check("taken_pulse", 32'(pc_taken), 32'h0);
        pc_write_cond = 1; cond_mode = 3'd1; pc_source = 2'd1; aluout = 32'h80; step();
        check("ne_pc", pc, 32'h40);
        check("ne_cnt", 32'(branch_count), 32'h1);

        // all modes against flag pairs, bypassed in the branching cycle
        for (int m = 0; m < 8; m++) begin
            for (int f = 0; f < 3; f++) begin
                flags_load = 1; alu_zero = (f == 1); alu_gt = (f == 2);
                pc_write_cond = 1; cond_mode = 3'(m); pc_source = 2'd2;
                jump_target = 32'h1000 + 32'((m * 3 + f) * 4);
                step();
            end
        end

        // both write enables: unconditional, counter untouched
        step();
        pc_write = 1; pc_write_cond = 1; cond_mode = 3'd6; pc_source = 2'd2; jump_target = 32'h100;
        begin : both_blk
            logic [CW-1:0] c0;
            c0 = branch_count;
            step();
            check("both_pc", pc, 32'h100);
            check("both_cnt", 32'(branch_count), 32'(c0));
        end
        pc_write_cond = 1; cond_mode = 3'd6; pc_source = 2'd1; aluout = 32'h42; step();
        check("mis_pc", pc, 32'h100);
        check("mis_flag", 32'(misaligned), 32'h1);
        check("mis_taken", 32'(pc_taken), 32'h0);
        pc_write = 1; pc_source = 2'd3; exc_code = 2'd2; step();
        check("exc_pc", pc, 32'h88);
        check("exc_mis", 32'(misaligned), 32'h0);

        // epc sees the pre-update pc
        pc_write = 1; pc_source = 2'd2; jump_target = 32'h1C; step();
        epc_write = 1; pc_write = 1; pc_source = 2'd2; jump_target = 32'h20; step();
        check("epc_val", epc, 32'h1C);
        check("epc_pc", pc, 32'h20);

        // reset in the middle of a load
        pc_write = 1; pc_source = 2'd2; jump_target = 32'h200;
        #3 reset = 0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_taken", 32'(pc_taken), 32'h0);
        @(posedge clk); #1;
        check("arst_hold_pc", pc, 32'h0);
        check("arst_hold_taken", 32'(pc_taken), 32'h0);
        idle();
        model_reset();
        reset = 1;
        step();

        // counter saturation
        for (int i = 0; i < 17; i++) begin
            pc_write_cond = 1; cond_mode = 3'd6; pc_source = 2'd1; aluout = 32'(i * 4 + 4);
            step();
        end
        check("sat_cnt", 32'(branch_count), 32'hF);
        check("sat_taken", 32'(pc_taken), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
